// File: rtl/poly_use_hint_ctrl_if.sv
// Control and memory-port bundle for poly_use_hint_ctrl.
// The master side is the controller; the slave side is the requester plus coefficient/hint/w1 memories.
interface poly_use_hint_ctrl_if #(
  parameter int AW = 8
);
  logic               start;
  logic               abort;
  logic               busy;
  logic               done;
  logic               err;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic signed [31:0] rd_coef;
  logic               rd_hint;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [3:0]         wr_data;

  modport master (
    input  start, abort, rd_coef, rd_hint,
    output busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, abort, rd_coef, rd_hint,
    input  busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/poly_use_hint_ctrl.sv
// Streams one polynomial through UseHint (gamma2 = (q-1)/32), writing 4-bit w1 per coefficient.
// Optional hint-count check against OMEGA when USE_HINT_OMEGA_CHECK_EN is defined.
module poly_use_hint_ctrl #(
  parameter int N     = 256,
  parameter int OMEGA = 55,
  parameter int AW    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  poly_use_hint_ctrl_if.master bus
);

  localparam logic [AW-1:0]      LAST_ADDR = AW'(N - 1);
  localparam logic signed [32:0] Q         = 33'sd8380417;
  localparam logic signed [31:0] HALF_Q    = 32'sd4190208;
  localparam logic [31:0]        TWO_G2    = 32'd523776;

  if (OMEGA < 1 || OMEGA >= N || N != (1 << AW)) begin : g_param_check
    $error("poly_use_hint_ctrl: need N == 2**AW and 1 <= OMEGA < N");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic          rd_en_q;
  logic          busy_q;
  logic          done_q;
  logic          drain_q;
  logic          s1_v;
  logic [AW-1:0] s1_addr;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [3:0]    wr_data_q;
  logic [AW-1:0] rd_addr_w;

`ifdef USE_HINT_OMEGA_CHECK_EN
  localparam int HW = $clog2(OMEGA + 2);
  logic [HW-1:0] hcnt;
  logic          err_q;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign rd_addr_w   = rd_en_q ? cnt : '0;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_w;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

  // Decompose + UseHint. Input is taken as lying in (-q, 2q) and folded once into [0, q).
  logic signed [32:0] r;
  logic [22:0]        a;
  logic [16:0]        t1;
  logic [26:0]        p;
  logic [3:0]         a1;
  logic signed [31:0] a0;
  logic [3:0]         w1;

  always_comb begin
    r = {bus.rd_coef[31], bus.rd_coef};
    if (r < 0)
      r = r + Q;
    else if (r >= Q)
      r = r - Q;
    a  = 23'(r);
    t1 = 17'((24'(a) + 24'd127) >> 7);
    p  = 27'(t1) * 27'd1025 + 27'd2097152;
    a1 = 4'(p >> 22);
    a0 = $signed(32'(a)) - $signed(32'(a1) * TWO_G2);
    if (a0 > HALF_Q)
      a0 = a0 - 32'sd8380417;
    if (!bus.rd_hint)
      w1 = a1;
    else if (a0 > 0)
      w1 = a1 + 4'd1;
    else
      w1 = a1 - 4'd1;
  end

  // rd_coef/rd_hint arrive registered by the memory one cycle after rd_en, so they act as the
  // stage-1 data word; s1_* carries the matching valid/address alongside them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drain_q   <= 1'b0;
      s1_v      <= 1'b0;
      s1_addr   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef USE_HINT_OMEGA_CHECK_EN
      hcnt      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      s1_v      <= rd_en_q;
      s1_addr   <= rd_addr_w;
      wr_en_q   <= s1_v;
      wr_addr_q <= s1_v ? s1_addr : '0;
      wr_data_q <= s1_v ? w1 : '0;
      done_q    <= 1'b0;
`ifdef USE_HINT_OMEGA_CHECK_EN
      if (s1_v && bus.rd_hint && hcnt <= HW'(OMEGA))
        hcnt <= hcnt + HW'(1);
`endif
      if (bus.abort && state != S_IDLE) begin
        state     <= S_IDLE;
        rd_en_q   <= 1'b0;
        busy_q    <= 1'b0;
        s1_v      <= 1'b0;
        wr_en_q   <= 1'b0;
        wr_addr_q <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              state   <= S_RUN;
              cnt     <= '0;
              rd_en_q <= 1'b1;
              busy_q  <= 1'b1;
`ifdef USE_HINT_OMEGA_CHECK_EN
              hcnt    <= '0;
              err_q   <= 1'b0;
`endif
            end
          end
          S_RUN: begin
            if (cnt == LAST_ADDR) begin
              rd_en_q <= 1'b0;
              drain_q <= 1'b0;
              state   <= S_DRAIN;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
          S_DRAIN: begin
            if (drain_q) begin
              state  <= S_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
`ifdef USE_HINT_OMEGA_CHECK_EN
              err_q  <= (hcnt > HW'(OMEGA));
`endif
            end else begin
              drain_q <= 1'b1;
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_poly_use_hint_ctrl.sv
// Directed bench for poly_use_hint_ctrl: datapath vectors, run timing, abort, reset, hint count.
module tb_poly_use_hint_ctrl;
  localparam int N  = 256;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  poly_use_hint_ctrl_if #(.AW(AW)) bus ();

  poly_use_hint_ctrl #(.N(N), .OMEGA(55), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Memory model: one-cycle read latency.
  logic signed [31:0] mem_c [N];
  logic               mem_h [N];
  int                 exp_w [N];

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_coef <= mem_c[bus.rd_addr];
      bus.rd_hint <= mem_h[bus.rd_addr];
    end else begin
      bus.rd_coef <= '0;
      bus.rd_hint <= 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records per-run activity relative to the cycle in which start was raised.
  int t0 = 0, run_tag = 0, seen_tag = 0, rc;
  int rd_cnt, rd_first, rd_last, rd_seq_err;
  int wr_cnt, wr_first, wr_last;
  int busy_cnt, busy_first, busy_last;
  int done_cnt, done_rc, err_at_done;
  int gate_viol = 0;
  int wr_addr_log [N];
  int wr_data_log [N];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (seen_tag != run_tag) begin
        seen_tag = run_tag;
        rd_cnt = 0; rd_first = -1; rd_last = -1; rd_seq_err = 0;
        wr_cnt = 0; wr_first = -1; wr_last = -1;
        busy_cnt = 0; busy_first = -1; busy_last = -1;
        done_cnt = 0; done_rc = -1; err_at_done = -1;
        for (int i = 0; i < N; i++) begin
          wr_addr_log[i] = -1;
          wr_data_log[i] = -1;
        end
      end
      rc = cyc - t0;
      if (bus.rd_en) begin
        if (int'(bus.rd_addr) != rd_cnt) rd_seq_err++;
        if (rd_first < 0) rd_first = rc;
        rd_last = rc;
        rd_cnt++;
      end
      if (bus.wr_en) begin
        if (wr_cnt < N) begin
          wr_addr_log[wr_cnt] = int'(bus.wr_addr);
          wr_data_log[wr_cnt] = int'(bus.wr_data);
        end
        if (wr_first < 0) wr_first = rc;
        wr_last = rc;
        wr_cnt++;
      end
      if (bus.busy) begin
        if (busy_first < 0) busy_first = rc;
        busy_last = rc;
        busy_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        done_rc = rc;
        err_at_done = int'(bus.err);
      end
      if (!bus.rd_en && bus.rd_addr != '0) gate_viol++;
      if (!bus.wr_en && bus.wr_addr != '0) gate_viol++;
    end
  end

  task automatic do_start();
    @(negedge clk);
    t0 = cyc;
    run_tag++;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_rc(input int k);
    while (cyc - t0 < k) @(negedge clk);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"},    int'(bus.busy),    0);
    check({pfx, "_done"},    int'(bus.done),    0);
    check({pfx, "_err"},     int'(bus.err),     0);
    check({pfx, "_rd_en"},   int'(bus.rd_en),   0);
    check({pfx, "_wr_en"},   int'(bus.wr_en),   0);
    check({pfx, "_rd_addr"}, int'(bus.rd_addr), 0);
    check({pfx, "_wr_addr"}, int'(bus.wr_addr), 0);
    check({pfx, "_wr_data"}, int'(bus.wr_data), 0);
  endtask

  task automatic set_word(input int k, input int coef, input logic h, input int w);
    mem_c[k] = coef;
    mem_h[k] = h;
    exp_w[k] = w;
  endtask

  task automatic fill_run1();
    for (int k = 8; k < N; k++) set_word(k, (k % 16) * 523776, 1'b0, k % 16);
    set_word(0, 1571338, 1'b1, 4);
    set_word(1, 1571338, 1'b0, 3);
    set_word(2, 1571318, 1'b1, 2);
    set_word(3, 7856645, 1'b1, 0);
    set_word(4, 0,       1'b1, 15);
    set_word(5, 8380416, 1'b1, 15);
    set_word(6, 261888,  1'b1, 1);
    set_word(7, 261889,  1'b0, 1);
  endtask

  // a1 = k%16 with a0 = +5, so a set hint rounds w1 up by one (mod 16).
  task automatic fill_hints(input int nh);
    for (int k = 0; k < N; k++) begin
      if (k < nh) set_word(k, (k % 16) * 523776 + 5, 1'b1, ((k % 16) + 1) % 16);
      else        set_word(k, (k % 16) * 523776 + 5, 1'b0, k % 16);
    end
  endtask

  task automatic check_full_run(input string pfx);
    check({pfx, "_rd_cnt"},     rd_cnt,     N);
    check({pfx, "_rd_first"},   rd_first,   1);
    check({pfx, "_rd_last"},    rd_last,    N);
    check({pfx, "_rd_seq"},     rd_seq_err, 0);
    check({pfx, "_wr_cnt"},     wr_cnt,     N);
    check({pfx, "_wr_first"},   wr_first,   3);
    check({pfx, "_wr_last"},    wr_last,    N + 2);
    check({pfx, "_done_cnt"},   done_cnt,   1);
    check({pfx, "_done_rc"},    done_rc,    N + 3);
    check({pfx, "_busy_cnt"},   busy_cnt,   N + 2);
    check({pfx, "_busy_first"}, busy_first, 1);
    check({pfx, "_busy_last"},  busy_last,  N + 2);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_wr_addr[%0d]", pfx, i), wr_addr_log[i], i);
      check($sformatf("%s_wr_data[%0d]", pfx, i), wr_data_log[i], exp_w[i]);
    end
  endtask

`ifdef USE_HINT_OMEGA_CHECK_EN
  localparam int ERR56 = 1;
`else
  localparam int ERR56 = 0;
`endif

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Run 1: datapath vectors; stray starts in RUN and DONE must not disturb anything.
    fill_run1();
    do_start();
    wait_rc(20);
    pulse_start();
    wait_rc(N + 3);
    pulse_start();
    wait_rc(N + 20);
    check_full_run("r1");
    check("r1_err_at_done", err_at_done, 0);

    // Run 2: abort at cycle 100.
    do_start();
    wait_rc(100);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("ab_wr_en_101", int'(bus.wr_en), 0);
    check("ab_rd_en_101", int'(bus.rd_en), 0);
    check("ab_busy_101",  int'(bus.busy),  0);
    wait_rc(140);
    check("ab_done_cnt",  done_cnt,  0);
    check("ab_wr_cnt",    wr_cnt,    98);
    check("ab_wr_last",   wr_last,   100);
    check("ab_rd_last",   rd_last,   100);
    check("ab_busy_last", busy_last, 100);

    // Run 3: 56 hint bits set, straight after the aborted run.
    fill_hints(56);
    do_start();
    wait_rc(N + 12);
    check_full_run("h56");
    check("h56_err_at_done", err_at_done, ERR56);
    check("h56_err_held", int'(bus.err), ERR56);

    // Run 4: exactly OMEGA hint bits set.
    fill_hints(55);
    do_start();
    wait_rc(N + 12);
    check_full_run("h55");
    check("h55_err_at_done", err_at_done, 0);
    check("h55_err_held", int'(bus.err), 0);

    // Run 5: reset mid-run at cycle 50, then nothing may follow until a new start.
    do_start();
    wait_rc(50);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    run_tag++;
    repeat (300) @(negedge clk);
    check("post_rst_rd_cnt",   rd_cnt,   0);
    check("post_rst_wr_cnt",   wr_cnt,   0);
    check("post_rst_done_cnt", done_cnt, 0);
    check("post_rst_busy_cnt", busy_cnt, 0);

    check("gating_violations", gate_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
